// File: rtl/adder_seq_ctrl.sv
// Sequential W-bit adder: it drives an external combinational 4-bit adder slice one nibble per cycle.
// Optional macro ADDER_SEQ_SUB_EN adds a 'sub' port that selects A-B (B inverted, carry-in forced to 1).
module adder_seq_ctrl #(
    parameter int N_NIB = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*N_NIB-1:0]   op_a,
    input  logic [4*N_NIB-1:0]   op_b,
    input  logic                 cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic [3:0]           slice_a,
    output logic [3:0]           slice_b,
    output logic                 slice_c0,
    input  logic [3:0]           slice_f,
    input  logic                 slice_c4,
    output logic                 busy,
    output logic                 done,
    output logic [4*N_NIB-1:0]   sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W  = 4 * N_NIB;
    localparam int KW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            cin_q;
    logic            c4_q;
    logic            cmsb_q;
    logic [KW-1:0]   k;
    logic [W-1:0]    b_cap;
    logic            cin_cap;

    always_comb begin
        b_cap   = op_b;
        cin_cap = cin;
`ifdef ADDER_SEQ_SUB_EN
        if (sub) begin
            b_cap   = ~op_b;
            cin_cap = 1'b1;
        end
`endif
    end

    always_comb begin
        slice_a  = '0;
        slice_b  = '0;
        slice_c0 = 1'b0;
        if (state == RUN) begin
            slice_a  = a_q[{k, 2'b00} +: 4];
            slice_b  = b_q[{k, 2'b00} +: 4];
            slice_c0 = (k == '0) ? cin_q : c4_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            c4_q   <= 1'b0;
            cmsb_q <= 1'b0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_q   <= op_a;
                        b_q   <= b_cap;
                        cin_q <= cin_cap;
                        c4_q  <= 1'b0;
                        k     <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    sum[{k, 2'b00} +: 4] <= slice_f;
                    c4_q                 <= slice_c4;
                    k                    <= k + 1'b1;
                    if (k == K_LAST) begin
                        // The carry into the MSB is recovered from the sum bit: f = a ^ b ^ c.
                        cmsb_q <= a_q[W-1] ^ b_q[W-1] ^ slice_f[3];
                        k      <= '0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    cout  <= c4_q;
                    ovf   <= cmsb_q ^ c4_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (N_NIB=4), with a behavioural model of the 4-bit slice.
module tb_adder_seq_ctrl;

    localparam int N_NIB = 4;
    localparam int W     = 4 * N_NIB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cin;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
`ifdef ADDER_SEQ_SUB_EN
    logic          sub;
`endif
    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic          slice_c0;
    logic [3:0]    slice_f;
    logic          slice_c4;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t          sb[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [W-1:0]  last_sum;

    always #5 clk = ~clk;

    always_comb {slice_c4, slice_f} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_c0};

    adder_seq_ctrl #(.N_NIB(N_NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef ADDER_SEQ_SUB_EN
        .sub      (sub),
`endif
        .slice_a  (slice_a),
        .slice_b  (slice_b),
        .slice_c0 (slice_c0),
        .slice_f  (slice_f),
        .slice_c4 (slice_c4),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input string name);
        exp_t            e;
        logic [W-1:0]    bb;
        logic            cc;
        logic [W:0]      full;
        longint unsigned av, bv, m;
        int              lat, bad;
        logic [3:0]      ea, eb;
        logic            ec;
        string           msg;
        bb     = s ? ~b : b;
        cc     = s ? 1'b1 : c;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        av     = a;
        bv     = bb;
        msg    = "";
        op_a   = a;
        op_b   = b;
        cin    = c;
`ifdef ADDER_SEQ_SUB_EN
        sub    = s;
`endif
        start  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bad   = 0;
        while (lat < 20 && done !== 1'b1) begin
            if (lat < N_NIB) begin
                m  = (64'd1 << (4 * lat)) - 64'd1;
                ea = 4'((av >> (4 * lat)) & 64'hF);
                eb = 4'((bv >> (4 * lat)) & 64'hF);
                ec = 1'((((av & m) + (bv & m) + {63'd0, cc}) >> (4 * lat)));
            end else begin
                ea = 4'h0;
                eb = 4'h0;
                ec = 1'b0;
            end
            if ({slice_a, slice_b, slice_c0, busy} !== {ea, eb, ec, 1'b1}) begin
                if (bad == 0)
                    msg = $sformatf("cycle %0d got a=%h b=%h c0=%b busy=%b want a=%h b=%h c0=%b busy=1",
                                    lat, slice_a, slice_b, slice_c0, busy, ea, eb, ec);
                bad++;
            end
            @(negedge clk);
            lat++;
        end
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: done not seen within %0d cycles, want %0d", name, lat, N_NIB + 1);
            void'(sb.pop_front());
        end else begin
            n_chk++;
            if (lat != N_NIB + 1) begin
                n_fail++;
                $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, N_NIB + 1);
            end
            n_chk++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL %s slice drive: %s", name, msg);
            end
            e = sb.pop_front();
            n_chk++;
            if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                n_fail++;
                $display("FAIL %s result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         name, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            n_chk++;
            if ({busy, slice_a, slice_b, slice_c0} !== 10'd0) begin
                n_fail++;
                $display("FAIL %s idle outputs: got busy=%b a=%h b=%h c0=%b, want all 0",
                         name, busy, slice_a, slice_b, slice_c0);
            end
            last_sum = e.sum;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        cin   = 1'b0;
        op_a  = '0;
        op_b  = '0;
`ifdef ADDER_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, sum, cout, ovf, slice_a, slice_b, slice_c0} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy, done, sum} !== 18'd0) begin
            n_fail++;
            $display("FAIL after release: got busy=%b done=%b sum=%h, want 0", busy, done, sum);
        end
    endtask

    task automatic test_add();
        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, "add");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_chain");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "overflow");
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, "cin_only");
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, "neg_overflow");
    endtask

    task automatic test_hold();
        repeat (3) @(negedge clk);
        n_chk++;
        if (sum !== last_sum || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got sum=%h done=%b, want sum=%h done=0", sum, done, last_sum);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "random");
    endtask

    task automatic test_busy();
        exp_t e;
        int   dn, dcyc;
        logic busy5;
        op_a  = 16'h1111;
        op_b  = 16'h2222;
        cin   = 1'b0;
        start = 1'b1;
        e.sum = 16'h3333;
        e.cout = 1'b0;
        e.ovf = 1'b0;
        sb.push_back(e);
        dn    = 0;
        dcyc  = 0;
        busy5 = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dn++;
                if (dcyc == 0) dcyc = i;
            end
            if (i == 5) busy5 = busy;
            start = (i == 2 || i == 5);
            if (start) begin
                op_a = 16'hAAAA + 16'(i);
                op_b = 16'h5555;
                cin  = 1'b1;
            end
            if (i == 6) begin
                e = sb.pop_front();
                n_chk++;
                if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                    n_fail++;
                    $display("FAIL busy result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, e.sum, e.cout, e.ovf);
                end
            end
        end
        n_chk++;
        if (dn != 1 || dcyc != 6) begin
            n_fail++;
            $display("FAIL busy done count: got %0d pulses first at cycle %0d, want 1 at cycle 6", dn, dcyc);
        end
        n_chk++;
        if (busy5 !== 1'b1 || busy !== 1'b0 || sum !== 16'h3333) begin
            n_fail++;
            $display("FAIL busy flags: got busy_done=%b busy_end=%b sum=%h, want 1 0 3333",
                     busy5, busy, sum);
        end
        last_sum = 16'h3333;
    endtask

    task automatic test_reset_abort();
        int dn;
        op_a  = 16'h1234;
        op_b  = 16'h1111;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (sum !== 16'h0005 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort pre-reset: got sum=%h busy=%b, want sum=0005 busy=1", sum, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, sum, cout, ovf, slice_a, slice_b, slice_c0} !== 29'd0) begin
            n_fail++;
            $display("FAIL abort async clear: got busy=%b done=%b sum=%h cout=%b ovf=%b a=%h c0=%b, want all 0",
                     busy, done, sum, cout, ovf, slice_a, slice_c0);
        end
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
        end
        n_chk++;
        if (dn != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort no done: got %0d done cycles busy=%b, want 0 and busy=0", dn, busy);
        end
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "after_abort");
    endtask

`ifdef ADDER_SEQ_SUB_EN
    task automatic test_sub();
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_neg");
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_cin_ignored");
        do_op(16'h0005, 16'h0007, 1'b0, 1'b0, "add_after_sub");
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_hold();
        test_random();
        test_busy();
        test_hold();
        test_reset_abort();
`ifdef ADDER_SEQ_SUB_EN
        test_sub();
`endif
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
